axi_r_burst_buffer: RTL



---
 rtl/axi_buf_pkg.sv | 18 +
 rtl/fifo_core.sv | 49 ++++
 rtl/axi_r_burst_buffer.sv | 105 ++++++++++
 3 files changed

// File: rtl/axi_buf_pkg.sv
// Shared definitions for the AXI R-channel burst buffer.
//   - AXI response codes
//   - r_beat_w(): packed width of one stored R beat {id, user, data, resp, last}
package axi_buf_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // id + user + data + resp(2) + last(1)
  function automatic int unsigned r_beat_w(input int unsigned id_w,
                                           input int unsigned user_w,
                                           input int unsigned data_w);
    return id_w + user_w + data_w + 3;
  endfunction

endpackage

// File: rtl/fifo_core.sv
// Plain synchronous FIFO storage used by the R burst buffer.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/pop_i   write/read strobes (caller guarantees not full/not empty)
//   wdata_i        entry written on push
//   rdata_o        head entry (combinational from the read pointer)
//   fill_o         number of entries held
module fifo_core #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     fill_q;

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      fill_q <= fill_q + 1'b1;
      else if (!push_i && pop_i) fill_q <= fill_q - 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign fill_o  = fill_q;

endmodule

// File: rtl/axi_r_burst_buffer.sv
// AXI R-channel buffer with burst awareness.
// Stores R beats in a BUFFER_DEPTH-entry FIFO. With STORE_FWD=1 beats are only
// released once a complete burst (a beat with last) is held, or the buffer is
// full (prevents deadlock on bursts longer than the buffer).
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   test_en_i                     reserved, no functional effect
//   slave_*                       upstream R beat and handshake
//   master_*                      downstream R beat and handshake
//   fill_o, bursts_o              entries held, complete bursts held
//   resp_err_o, err_clr_i         sticky SLVERR/DECERR flag and its clear
module axi_r_burst_buffer
  import axi_buf_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned USER_WIDTH   = 6,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned STORE_FWD    = 0,
  parameter int unsigned CNT_W        = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  slave_valid_i,
  output logic                  slave_ready_o,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic                  slave_last_i,
  output logic                  master_valid_o,
  input  logic                  master_ready_i,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic                  master_last_o,
  output logic [CNT_W-1:0]      fill_o,
  output logic [CNT_W-1:0]      bursts_o,
  output logic                  resp_err_o,
  input  logic                  err_clr_i
);

  localparam int unsigned BeatW = r_beat_w(ID_WIDTH, USER_WIDTH, DATA_WIDTH);

  logic             unused_test_en;
  logic [BeatW-1:0] wbeat, rbeat;
  logic [CNT_W-1:0] fill, bursts_q;
  logic             push, pop, full, empty, err_q;

  assign unused_test_en = test_en_i;

  assign wbeat = {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};

  fifo_core #(
    .DEPTH  (BUFFER_DEPTH),
    .DATA_W (BeatW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wbeat),
    .rdata_o (rbeat),
    .fill_o  (fill)
  );

  assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = rbeat;

  assign full  = (fill == CNT_W'(BUFFER_DEPTH));
  assign empty = (fill == '0);

  // Ready depends only on registered fill: a full buffer never accepts in the
  // cycle it pops.
  assign slave_ready_o = !full;
  assign push          = slave_valid_i & slave_ready_o;
  assign pop           = master_valid_o & master_ready_i;

  always_comb begin
    master_valid_o = !empty;
    if (STORE_FWD != 0) master_valid_o = !empty && ((bursts_q != '0) || full);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bursts_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case ({push && slave_last_i, pop && master_last_o})
        2'b10:   bursts_q <= bursts_q + 1'b1;
        2'b01:   bursts_q <= bursts_q - 1'b1;
        default: bursts_q <= bursts_q;
      endcase
      // Set wins over clear.
      if (push && slave_resp_i[1]) err_q <= 1'b1;
      else if (err_clr_i)          err_q <= 1'b0;
    end
  end

  assign fill_o     = fill;
  assign bursts_o   = bursts_q;
  assign resp_err_o = err_q;

endmodule
